// File: rtl/snn_pkg.sv
// Shared types, default widths and helpers for the spiking-network tile blocks
// (lif, synapse, spike_rate_decoder).
package snn_pkg;

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   localparam int unsigned DATA_W         = 8;
   localparam int unsigned CNT_W_DEF      = DATA_W;
   localparam int unsigned ISI_W_DEF      = DATA_W;
   localparam int unsigned WINDOW_LEN_DEF = 256;

   // Saturating increment on a 32-bit carrier; callers cast back to their own width.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      logic [31:0] res;
      if (val >= max_val) begin
         res = max_val;
      end else begin
         res = val + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result slot of the spike rate decoder: count/interval payload with a
// valid/ready handshake and a drop indication.
interface spike_rate_decoder_if
   import snn_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned ISI_W = ISI_W_DEF
);

   logic [CNT_W-1:0] rate_o;
   logic [ISI_W-1:0] isi_o;
   logic             valid_o;
   logic             ready_i;
   logic             drop_o;

   modport master (
      output rate_o,
      output isi_o,
      output valid_o,
      output drop_o,
      input  ready_i
   );

   modport slave (
      input  rate_o,
      input  isi_o,
      input  valid_o,
      input  drop_o,
      output ready_i
   );

endinterface

// File: rtl/isi_tracker.sv
// Inter-spike interval counter plus the running minimum for the current window.
// cur_min already folds in the present cycle's spike so the window close sees it.
module isi_tracker
   import snn_pkg::*;
#(
   parameter int unsigned ISI_W = ISI_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             spike_i,
   input  logic             win_start,
   output logic [ISI_W-1:0] cur_min
);

   localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

   logic [ISI_W-1:0] isi_cnt_q;
   logic [ISI_W-1:0] isi_cnt_d;
   logic [ISI_W-1:0] min_q;
   logic [ISI_W-1:0] min_d;
   logic [ISI_W-1:0] min_base_s;
   logic             hit_s;

   always_comb begin
      hit_s      = en_i & spike_i;
      min_base_s = min_q;
      if (win_start) begin
         min_base_s = ISI_MAX;
      end else begin
         min_base_s = min_q;
      end

      cur_min = min_base_s;
      if (hit_s && (isi_cnt_q < min_base_s)) begin
         cur_min = isi_cnt_q;
      end else begin
         cur_min = min_base_s;
      end

      // The counter runs across window boundaries so cross-window gaps are measured.
      isi_cnt_d = isi_cnt_q;
      min_d     = min_q;
      if (!en_i) begin
         isi_cnt_d = isi_cnt_q;
         min_d     = min_q;
      end else if (spike_i) begin
         isi_cnt_d = {{(ISI_W-1){1'b0}}, 1'b1};
         min_d     = cur_min;
      end else begin
         isi_cnt_d = ISI_W'(sat_inc(32'(isi_cnt_q), 32'(ISI_MAX)));
         min_d     = cur_min;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         isi_cnt_q <= ISI_MAX;
         min_q     <= ISI_MAX;
      end else begin
         isi_cnt_q <= isi_cnt_d;
         min_q     <= min_d;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a spike train into per-window spike count and minimum inter-spike
// interval, delivered through a single-entry valid/ready result slot.
module spike_rate_decoder
   import snn_pkg::*;
#(
   parameter int unsigned WINDOW_LEN = WINDOW_LEN_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned ISI_W      = ISI_W_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  spike_i,
   spike_rate_decoder_if.master  out_if
);

   localparam int unsigned      WIN_W    = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [WIN_W-1:0] win_q;
   logic [WIN_W-1:0] win_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             last_s;
   logic             win_start_s;
   logic [CNT_W-1:0] rate_fin_s;
   logic [ISI_W-1:0] cur_min_s;

   slot_state_e      state_q;
   slot_state_e      state_d;
   logic [CNT_W-1:0] rate_q;
   logic [CNT_W-1:0] rate_d;
   logic [ISI_W-1:0] isi_q;
   logic [ISI_W-1:0] isi_d;
   logic             valid_q;
   logic             valid_d;
   logic             drop_q;
   logic             drop_d;

   isi_tracker #(
      .ISI_W (ISI_W)
   ) u_isi_tracker (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .spike_i   (spike_i),
      .win_start (win_start_s),
      .cur_min   (cur_min_s)
   );

   always_comb begin
      win_start_s = (win_q == {WIN_W{1'b0}});
      if (en_i && (win_q == WIN_LAST)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end

      if (spike_i) begin
         rate_fin_s = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
      end else begin
         rate_fin_s = cnt_q;
      end

      win_d = win_q;
      cnt_d = cnt_q;
      if (!en_i) begin
         win_d = win_q;
         cnt_d = cnt_q;
      end else if (last_s) begin
         win_d = {WIN_W{1'b0}};
         cnt_d = {CNT_W{1'b0}};
      end else begin
         win_d = win_q + WIN_W'(1'b1);
         cnt_d = rate_fin_s;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_q <= {WIN_W{1'b0}};
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         win_q <= win_d;
         cnt_q <= cnt_d;
      end
   end

   // A completing window either fills the slot, replaces data leaving this cycle, or is dropped.
   always_comb begin
      state_d = state_q;
      rate_d  = rate_q;
      isi_d   = isi_q;
      drop_d  = 1'b0;
      case (state_q)
         SLOT_EMPTY: begin
            if (last_s) begin
               state_d = SLOT_FULL;
               rate_d  = rate_fin_s;
               isi_d   = cur_min_s;
            end else begin
               state_d = SLOT_EMPTY;
            end
         end
         SLOT_FULL: begin
            if (last_s && out_if.ready_i) begin
               state_d = SLOT_FULL;
               rate_d  = rate_fin_s;
               isi_d   = cur_min_s;
            end else if (last_s) begin
               state_d = SLOT_FULL;
               drop_d  = 1'b1;
            end else if (out_if.ready_i) begin
               state_d = SLOT_EMPTY;
            end else begin
               state_d = SLOT_FULL;
            end
         end
         default: begin
            state_d = SLOT_EMPTY;
         end
      endcase
      valid_d = (state_d == SLOT_FULL);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SLOT_EMPTY;
         rate_q  <= {CNT_W{1'b0}};
         isi_q   <= {ISI_W{1'b0}};
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rate_q  <= rate_d;
         isi_q   <= isi_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   assign out_if.rate_o  = rate_q;
   assign out_if.isi_o   = isi_q;
   assign out_if.valid_o = valid_q;
   assign out_if.drop_o  = drop_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench: directed windows push expected results, negedge monitors
// pop and compare on every valid&&ready transfer.
module tb_spike_rate_decoder;

   typedef struct {
      int rate;
      int isi;
      int at;
   } exp_t;

   logic clk;
   logic rst;
   logic en_a;
   logic spk_a;
   logic en_b;
   logic spk_b;
   int   cyc;
   int   n_chk;
   int   n_pass;
   int   drops_a;
   int   drops_b;
   exp_t qa[$];
   exp_t qb[$];

   spike_rate_decoder_if #(.CNT_W(8), .ISI_W(8)) if_a ();
   spike_rate_decoder_if #(.CNT_W(4), .ISI_W(8)) if_b ();

   spike_rate_decoder #(.WINDOW_LEN(16), .CNT_W(8), .ISI_W(8)) dut_a (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (en_a),
      .spike_i (spk_a),
      .out_if  (if_a)
   );

   spike_rate_decoder #(.WINDOW_LEN(16), .CNT_W(4), .ISI_W(8)) dut_b (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (en_b),
      .spike_i (spk_b),
      .out_if  (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      n_chk = n_chk + 1;
      if (act != exp) begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         n_pass = n_pass + 1;
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (if_a.drop_o) drops_a <= drops_a + 1;
      if (if_a.valid_o && if_a.ready_i) begin
         chk("a_xfer_expected", (qa.size() > 0) ? 1 : 0, 1);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_rate", int'(if_a.rate_o), e.rate);
            chk("a_isi", int'(if_a.isi_o), e.isi);
            if (e.at >= 0) chk("a_xfer_cycle", cyc, e.at);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (if_b.drop_o) drops_b <= drops_b + 1;
      if (if_b.valid_o && if_b.ready_i) begin
         chk("b_xfer_expected", (qb.size() > 0) ? 1 : 0, 1);
         if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_rate", int'(if_b.rate_o), e.rate);
            chk("b_isi", int'(if_b.isi_o), e.isi);
            if (e.at >= 0) chk("b_xfer_cycle", cyc, e.at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic en, input logic sp, input logic rd);
      if (sel == 0) begin
         en_a  = en;
         spk_a = sp;
         en_b  = 1'b0;
         spk_b = 1'b0;
      end else begin
         en_a  = 1'b0;
         spk_a = 1'b0;
         en_b  = en;
         spk_b = sp;
      end
      if_a.ready_i = rd;
      if_b.ready_i = rd;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   // gap_len disabled cycles (with spike_i held high) are inserted before window cycle gap_at.
   task automatic run_window(input int sel, input logic [15:0] mask, input logic rd,
                             input logic rd_last, input int gap_at, input int gap_len);
      for (int i = 0; i < 16; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               drive(sel, 1'b0, 1'b1, rd);
               tick();
            end
         end
         drive(sel, 1'b1, mask[i], (i == 15) ? rd_last : rd);
         tick();
      end
   endtask

   task automatic push_a(input int rate, input int isi, input int at);
      exp_t e;
      e.rate = rate;
      e.isi  = isi;
      e.at   = at;
      qa.push_back(e);
   endtask

   task automatic push_b(input int rate, input int isi, input int at);
      exp_t e;
      e.rate = rate;
      e.isi  = isi;
      e.at   = at;
      qb.push_back(e);
   endtask

   initial begin
      int d0;
      n_chk   = 0;
      n_pass  = 0;
      drops_a = 0;
      drops_b = 0;
      rst     = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_rate", int'(if_a.rate_o), 0);
      chk("rst_isi", int'(if_a.isi_o), 0);
      chk("rst_valid", int'(if_a.valid_o), 0);
      chk("rst_drop", int'(if_a.drop_o), 0);
      chk("rst_valid_b", int'(if_b.valid_o), 0);
      rst = 1'b0;

      // Regular train, then a window whose first interval spans the boundary.
      push_a(4, 4, cyc + 16);
      run_window(0, 16'h1111, 1'b1, 1'b1, -1, 0);
      drive(0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("regular_valid_clears", int'(if_a.valid_o), 0);
      push_a(2, 4, cyc + 16);
      run_window(0, 16'h0401, 1'b1, 1'b1, -1, 0);
      drive(0, 1'b0, 1'b0, 1'b1);
      tick();

      // Single spike, then an empty window.
      do_reset();
      push_a(1, 255, cyc + 16);
      run_window(0, 16'h0080, 1'b1, 1'b1, -1, 0);
      push_a(0, 255, cyc + 16);
      run_window(0, 16'h0000, 1'b1, 1'b1, -1, 0);
      drive(0, 1'b0, 1'b0, 1'b1);
      tick();

      // Backpressure across two windows: second result dropped, first held.
      do_reset();
      d0 = drops_a;
      push_a(4, 4, -1);
      run_window(0, 16'h1111, 1'b0, 1'b0, -1, 0);
      run_window(0, 16'h0101, 1'b0, 1'b0, -1, 0);
      chk("bp_held_rate", int'(if_a.rate_o), 4);
      chk("bp_held_isi", int'(if_a.isi_o), 4);
      chk("bp_valid", int'(if_a.valid_o), 1);
      chk("bp_drop_pulse", int'(if_a.drop_o), 1);
      drive(0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("bp_drop_one_cycle", int'(if_a.drop_o), 0);
      chk("bp_valid_after_xfer", int'(if_a.valid_o), 0);
      chk("bp_drop_count", drops_a - d0, 1);

      // Accept on the same edge as a new load: no bubble, no drop.
      do_reset();
      d0 = drops_a;
      push_a(4, 4, -1);
      run_window(0, 16'h1111, 1'b0, 1'b0, -1, 0);
      push_a(2, 4, -1);
      run_window(0, 16'h0101, 1'b0, 1'b1, -1, 0);
      chk("sim_valid_stays", int'(if_a.valid_o), 1);
      chk("sim_no_drop", int'(if_a.drop_o), 0);
      drive(0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("sim_valid_after", int'(if_a.valid_o), 0);
      chk("sim_drop_count", drops_a - d0, 0);

      // Reset mid-window clears the slot and the partial window.
      do_reset();
      run_window(0, 16'h1111, 1'b0, 1'b0, -1, 0);
      chk("mid_rst_pre_valid", int'(if_a.valid_o), 1);
      for (int i = 0; i < 9; i++) begin
         drive(0, 1'b1, 1'b1, 1'b0);
         tick();
      end
      rst = 1'b1;
      drive(0, 1'b1, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      chk("mid_rst_rate", int'(if_a.rate_o), 0);
      chk("mid_rst_isi", int'(if_a.isi_o), 0);
      chk("mid_rst_valid", int'(if_a.valid_o), 0);
      chk("mid_rst_drop", int'(if_a.drop_o), 0);
      push_a(3, 3, cyc + 16);
      run_window(0, 16'h0824, 1'b1, 1'b1, -1, 0);
      drive(0, 1'b0, 1'b0, 1'b1);
      tick();

      // Enable gap of 5 cycles (spike_i high) delays completion by 5.
      do_reset();
      push_a(4, 4, cyc + 21);
      run_window(0, 16'h1111, 1'b1, 1'b1, 6, 5);
      drive(0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("gap_valid_after", int'(if_a.valid_o), 0);

      // Count saturation on the narrow-count instance.
      push_b(15, 1, cyc + 16);
      run_window(1, 16'hFFFF, 1'b1, 1'b1, -1, 0);
      push_b(15, 1, cyc + 16);
      run_window(1, 16'hFFFF, 1'b1, 1'b1, -1, 0);
      drive(1, 1'b0, 1'b0, 1'b1);
      tick();
      chk("b_valid_after", int'(if_b.valid_o), 0);
      chk("b_drop_count", drops_b, 0);

      tick();
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive-side counterpart of the LIF neuron. Consumes the 1-bit spike train a `lif` instance emits and decodes it back into numbers.
- Over a fixed observation window it produces two values:
  - the spike count (rate code);
  - the minimum inter-spike interval (burst/timing code).
- Each result is presented on a single-entry valid/ready output slot.
- Sits downstream of `lif` in the tile top. Its output feeds `uo_out` or a later layer.

Parameters:
- WINDOW_LEN, default 256: enabled cycles per observation window; must be ≥ 2.
- CNT_W, default 8: spike-count width; the count saturates at 2^CNT_W-1.
- ISI_W, default 8: interval width; the interval saturates at 2^ISI_W-1, and that value also means "no interval seen".

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- en_i  in  1  observation enable; when low, all counters freeze and spike_i is ignored.
- spike_i  in  1  spike from the neuron; one spike per cycle it is high (qualified by en_i).
- rate_o  out  CNT_W  spike count of the last completed window.
- isi_o  out  ISI_W  minimum inter-spike interval inside that window.
- valid_o  out  1  result slot full.
- ready_i  in  1  consumer accepts; a transfer occurs when valid_o && ready_i.
- drop_o  out  1  one-cycle pulse: a window result was lost because the slot was full.

Behaviour:
- Reset (rst_i=1, synchronous; overrides every other input, including mid-window):
  - window counter 0, spike count 0, window min-ISI all-ones;
  - ISI counter all-ones ("no prior spike");
  - slot EMPTY;
  - outputs: rate_o=0, isi_o=0, valid_o=0, drop_o=0.
- Window counter: increments by 1 on each en_i cycle over 0..WINDOW_LEN-1, then wraps to 0. The "last cycle" is win==WINDOW_LEN-1 with en_i=1.
- Spike count: increments on en_i&&spike_i and saturates at 2^CNT_W-1 (no wrap). It is cleared to 0 after the last cycle, so the next window starts fresh.
- ISI counter (sub-module), active on en_i cycles only:
  - on a spike: sample = current counter value, then counter loads 1;
  - otherwise: counter increments, saturating at all-ones.
  - The counter persists across window boundaries, so the interval between spikes in adjacent windows is measured correctly.
- Window min-ISI: on each spike it updates to min(min, sample). It resets to all-ones at the window start. Zero or one spike in a window therefore yields all-ones.
- Final result uses the last cycle's own spike:
  - rate = sat(count + spike);
  - isi = min including that cycle's sample.
- Output slot FSM, two states:
  - EMPTY → FULL: on the last cycle, load rate_o/isi_o and assert valid_o. Latency is 1 cycle after the last window cycle.
  - FULL, valid_o&&ready_i, no new result → EMPTY.
  - FULL, new result in the same cycle as the transfer → stay FULL and load the new data (no bubble, no drop).
  - FULL, new result, ready_i=0 → keep the old data and pulse drop_o for exactly one cycle (registered, same edge as the would-be load).
- rate_o/isi_o are stable while valid_o=1 and ready_i=0.
- en_i=0 on the last cycle: no completion; the window closes on the next enabled cycle.
- ready_i is ignored while EMPTY.

Decomposition:
- Package snn_pkg:
  - slot state enum (SLOT_EMPTY, SLOT_FULL);
  - default width localparams shared with `lif` and `synapse` (8-bit data);
  - sat_inc helper function.
- Sub-module isi_tracker holds the ISI counter and the window min-ISI register.
  - Inputs: clk_i, rst_i, en_i, spike_i, win_start.
  - Output: cur_min.

Test Plan (bench WINDOW_LEN=16 unless stated):
- Regular train: spikes at window cycles 0,4,8,12, ready_i=1 → valid_o for 1 cycle after cycle 15, rate_o=4, isi_o=4.
- Single spike at cycle 7; then an empty window → first result rate_o=1, isi_o=255. Second result rate_o=0, isi_o=255. The ISI counter keeps saturating at 255.
- Saturation with CNT_W=4: spike_i=1 every cycle → rate_o=15 (not 0), isi_o=1.
- Backpressure: 4 spikes/window, ready_i=0 for two windows → window-1 result held stable, valid_o=1, drop_o pulses once at the end of window 2. Raising ready_i → one transfer of rate_o=4, then valid_o=0.
- Simultaneous accept and load: ready_i asserted exactly on window-2's last cycle → window-1 data transferred, window-2 data loaded, valid_o stays 1, drop_o=0.
- Reset and enable:
  - rst_i=1 at window cycle 9 → all outputs 0 next cycle; the next result covers a full 16 cycles after release.
  - en_i low for 5 cycles mid-window → completion delayed by exactly 5 cycles and the count is unchanged.
